// File: rtl/y86_pkg.sv
// Shared Y86 definitions used by the branch predictor:
// instruction codes, the BHT index hash and saturating-counter constants.
package y86_pkg;

   // Y86-64 instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Widest supported counter and index; helpers return values at these widths
   localparam int CTR_W_MAX = 4;
   localparam int IDX_W_MAX = 10;

   // Source of the predicted next PC
   typedef enum logic [1:0] {
      PRED_FALL   = 2'd0,
      PRED_TARGET = 2'd1,
      PRED_RAS    = 2'd2
   } pred_sel_e;

   // Largest value of a saturating counter of the given width
   function automatic logic [CTR_W_MAX-1:0] ctr_sat_max(input int unsigned bits);
      return CTR_W_MAX'((32'd1 << bits) - 32'd1);
   endfunction

   // Weakly-taken reset value: only the MSB set
   function automatic logic [CTR_W_MAX-1:0] ctr_weak_taken(input int unsigned bits);
      return CTR_W_MAX'(32'd1 << (bits - 32'd1));
   endfunction

   // BHT index: low PC bits, with the low hist_bits XORed with global history.
   // hist_bits == 0 degenerates to plain bimodal indexing.
   function automatic logic [IDX_W_MAX-1:0] bht_index(
      input logic [63:0]          pc,
      input logic [IDX_W_MAX-1:0] ghr,
      input int unsigned          idx_bits,
      input int unsigned          hist_bits
   );
      logic [IDX_W_MAX-1:0] idx_mask;
      logic [IDX_W_MAX-1:0] hist_mask;
      idx_mask  = IDX_W_MAX'((32'd1 << idx_bits) - 32'd1);
      hist_mask = IDX_W_MAX'((32'd1 << hist_bits) - 32'd1);
      return (pc[IDX_W_MAX-1:0] & idx_mask) ^ (ghr & hist_mask);
   endfunction

endpackage

// File: rtl/bpred_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty is ignored; clear empties it and beats push/pop.
module bpred_ras
   import y86_pkg::*;
#(
   parameter int RAS_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic        clear,
   input  logic [63:0] wdata,
   output logic [63:0] top,
   output logic        empty
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

   logic [63:0]      mem [RAS_DEPTH];
   logic [PTR_W-1:0] sp;       // next slot to write; top lives at sp-1
   logic [CNT_W-1:0] cnt;      // occupancy, saturates at RAS_DEPTH
   logic [PTR_W-1:0] sp_top;

   assign sp_top = sp - PTR_W'(1);
   assign top    = mem[sp_top];
   assign empty  = (cnt == '0);

   // Stack pointer and occupancy; clear has priority over push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp  <= '0;
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (push) begin
         sp <= sp + PTR_W'(1);
         if (cnt != FULL_CNT) begin
            cnt <= cnt + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         sp  <= sp_top;
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Entry storage; contents are meaningless while occupancy hides them
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[sp] <= wdata;
      end
   end

endmodule

// File: rtl/bpred_gshare_ras.sv
// Fetch-stage next-PC predictor: bimodal/gshare BHT for conditional jumps,
// return-address stack for IRET, plus resolved-branch statistics.
module bpred_gshare_ras
   import y86_pkg::*;
#(
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_BITS    = 2,
   parameter int HIST_BITS   = 0,
   parameter int RAS_DEPTH   = 8
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        F_stall_i,
   input  logic [63:0] f_PC_i,
   input  logic [3:0]  f_icode_i,
   input  logic [3:0]  f_ifun_i,
   input  logic [63:0] f_valC_i,
   input  logic [63:0] f_valP_i,
   input  logic [63:0] E_PC_i,
   input  logic [3:0]  E_icode_i,
   input  logic [3:0]  E_ifun_i,
   input  logic        E_branch_taken_i,
   input  logic        e_Cnd_i,
   output logic [63:0] f_predPC_o,
   output logic        f_branch_taken_o,
   output logic        f_ras_hit_o,
   output logic [31:0] stat_branches_o,
   output logic [31:0] stat_mispred_o
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam int GHR_W = (HIST_BITS > 0) ? HIST_BITS : 1;

   localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_sat_max(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_weak_taken(CTR_BITS));

   // Saturating step of a prediction counter toward the resolved outcome
   function automatic logic [CTR_BITS-1:0] ctr_next(
      input logic [CTR_BITS-1:0] ctr,
      input logic                taken
   );
      if (taken) begin
         return (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
      end
      return (ctr == '0) ? ctr : ctr - CTR_BITS'(1);
   endfunction

   logic [CTR_BITS-1:0]  bht [BHT_ENTRIES];
   logic [GHR_W-1:0]     ghr;
   logic [IDX_W_MAX-1:0] ghr_ext;
   logic [IDX_W-1:0]     f_idx;
   logic [IDX_W-1:0]     e_idx;
   logic [CTR_BITS-1:0]  f_ctr;
   logic [CTR_BITS-1:0]  e_ctr;
   logic                 upd;
   logic                 mispred;
   pred_sel_e            pred_sel;

   logic                 ras_push;
   logic                 ras_pop;
   logic [63:0]          ras_top;
   logic                 ras_empty;

   assign ghr_ext = IDX_W_MAX'(ghr);
   assign f_idx   = IDX_W'(bht_index(f_PC_i, ghr_ext, IDX_W, HIST_BITS));
   assign e_idx   = IDX_W'(bht_index(E_PC_i, ghr_ext, IDX_W, HIST_BITS));
   assign f_ctr   = bht[f_idx];
   assign e_ctr   = bht[e_idx];

   // Only conditional jumps train the predictor
   assign upd     = (E_icode_i == IJXX) && (E_ifun_i != 4'h0);
   assign mispred = upd && (E_branch_taken_i != e_Cnd_i);

   // RAS moves only with a non-stalled fetch
   assign ras_push = !F_stall_i && (f_icode_i == ICALL);
   assign ras_pop  = !F_stall_i && (f_icode_i == IRET);

   bpred_ras #(
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .push  (ras_push),
      .pop   (ras_pop),
      .clear (mispred),
      .wdata (f_valP_i),
      .top   (ras_top),
      .empty (ras_empty)
   );

   // Fetch-time prediction: choose the next-PC source and the side flags
   always_comb begin
      pred_sel         = PRED_FALL;
      f_branch_taken_o = 1'b0;
      f_ras_hit_o      = 1'b0;
      case (f_icode_i)
         IJXX: begin
            if (f_ifun_i == 4'h0) begin
               pred_sel         = PRED_TARGET;
               f_branch_taken_o = 1'b1;
            end else if (f_ctr[CTR_BITS-1]) begin
               pred_sel         = PRED_TARGET;
               f_branch_taken_o = 1'b1;
            end
         end
         ICALL: begin
            pred_sel = PRED_TARGET;
         end
         IRET: begin
            if (!ras_empty) begin
               pred_sel    = PRED_RAS;
               f_ras_hit_o = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Next-PC mux
   always_comb begin
      f_predPC_o = f_valP_i;
      case (pred_sel)
         PRED_TARGET: f_predPC_o = f_valC_i;
         PRED_RAS:    f_predPC_o = ras_top;
         default:     f_predPC_o = f_valP_i;
      endcase
   end

   // BHT counters: written from execute; fetch sees the old value this cycle
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= CTR_INIT;
         end
      end else if (upd) begin
         bht[e_idx] <= ctr_next(e_ctr, e_Cnd_i);
      end
   end

   // Global history: shift in each resolved conditional outcome
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ghr <= '0;
      end else if (upd) begin
         ghr <= GHR_W'({ghr, e_Cnd_i});
      end
   end

   // Resolved-branch and misprediction counters, wrapping at 2^32
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stat_branches_o <= '0;
         stat_mispred_o  <= '0;
      end else begin
         if (upd) begin
            stat_branches_o <= stat_branches_o + 32'd1;
         end
         if (mispred) begin
            stat_mispred_o <= stat_mispred_o + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_bpred_gshare_ras.sv
// Directed scoreboard bench for bpred_gshare_ras (gshare, 4 history bits,
// 2-entry RAS). Stimulus queues expectations; a negedge monitor checks them.
module tb_bpred_gshare_ras;
   import y86_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        F_stall;
   logic [63:0] f_PC, f_valC, f_valP, E_PC;
   logic [3:0]  f_icode, f_ifun, E_icode, E_ifun;
   logic        E_branch_taken, e_Cnd;
   logic [63:0] predPC;
   logic        br_taken, ras_hit;
   logic [31:0] stat_br, stat_mp;

   bpred_gshare_ras #(
      .BHT_ENTRIES (64),
      .CTR_BITS    (2),
      .HIST_BITS   (4),
      .RAS_DEPTH   (2)
   ) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .F_stall_i        (F_stall),
      .f_PC_i           (f_PC),
      .f_icode_i        (f_icode),
      .f_ifun_i         (f_ifun),
      .f_valC_i         (f_valC),
      .f_valP_i         (f_valP),
      .E_PC_i           (E_PC),
      .E_icode_i        (E_icode),
      .E_ifun_i         (E_ifun),
      .E_branch_taken_i (E_branch_taken),
      .e_Cnd_i          (e_Cnd),
      .f_predPC_o       (predPC),
      .f_branch_taken_o (br_taken),
      .f_ras_hit_o      (ras_hit),
      .stat_branches_o  (stat_br),
      .stat_mispred_o   (stat_mp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          is_stat;
      logic [63:0] pc;
      logic        tk;
      logic        hit;
      logic [31:0] br;
      logic [31:0] mp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic void exp_pred(input string nm, input logic [63:0] pc,
                                    input logic tk, input logic hit);
      exp_t e;
      e.name = nm; e.is_stat = 1'b0; e.pc = pc; e.tk = tk; e.hit = hit;
      e.br = '0; e.mp = '0;
      sb.push_back(e);
   endfunction

   function automatic void exp_stat(input string nm, input logic [31:0] br,
                                    input logic [31:0] mp);
      exp_t e;
      e.name = nm; e.is_stat = 1'b1; e.pc = '0; e.tk = 1'b0; e.hit = 1'b0;
      e.br = br; e.mp = mp;
      sb.push_back(e);
   endfunction

   task automatic check(input string nm, input string field,
                        input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s.%s got %0h expected %0h", nm, field, got, want);
   endtask

   // Monitor: outputs are valid every cycle; compare everything queued for it
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         if (e.is_stat) begin
            check(e.name, "branches", 64'(stat_br), 64'(e.br));
            check(e.name, "mispred",  64'(stat_mp), 64'(e.mp));
         end else begin
            check(e.name, "predPC",  predPC, e.pc);
            check(e.name, "taken",   64'(br_taken), 64'(e.tk));
            check(e.name, "ras_hit", 64'(ras_hit), 64'(e.hit));
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      F_stall = 1'b0;
      f_icode = INOP; f_ifun = 4'h0; f_PC = '0; f_valC = '0; f_valP = '0;
      E_icode = INOP; E_ifun = 4'h0; E_PC = '0; E_branch_taken = 1'b0; e_Cnd = 1'b0;
   endtask

   task automatic fetch(input logic [3:0] ic, input logic [3:0] ifn,
                        input logic [63:0] pc, input logic [63:0] vc,
                        input logic [63:0] vp);
      f_icode = ic; f_ifun = ifn; f_PC = pc; f_valC = vc; f_valP = vp;
   endtask

   task automatic exec(input logic [63:0] pc, input logic tk, input logic cnd);
      E_icode = IJXX; E_ifun = 4'h1; E_PC = pc; E_branch_taken = tk; e_Cnd = cnd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic exp_tk;
      rst_n = 1'b0;
      F_stall = 1'b0;
      f_icode = INOP; f_ifun = 4'h0; f_PC = '0; f_valC = '0; f_valP = '0;
      E_icode = INOP; E_ifun = 4'h0; E_PC = '0; E_branch_taken = 1'b0; e_Cnd = 1'b0;

      // Stats held at zero while in reset
      exp_stat("reset_stats", 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Post-reset predictions
      next_cycle(); fetch(IJXX, 4'h1, 64'h100, 64'h200, 64'h109);
      exp_pred("rst_jcc", 64'h200, 1'b1, 1'b0);
      next_cycle(); fetch(IRET, 4'h0, 64'h120, 64'h0, 64'h55);
      exp_pred("rst_iret", 64'h55, 1'b0, 1'b0);
      next_cycle(); fetch(INOP, 4'h0, 64'h130, 64'h0, 64'h33);
      exp_pred("nop", 64'h33, 1'b0, 1'b0);
      next_cycle(); fetch(IJXX, 4'h0, 64'h140, 64'h300, 64'h400);
      exp_pred("jmp", 64'h300, 1'b1, 1'b0);

      // Train 0x100 not-taken twice; same-cycle fetch sees pre-update counter
      next_cycle(); fetch(IJXX, 4'h1, 64'h100, 64'h200, 64'h109);
      exec(64'h100, 1'b1, 1'b0);
      exp_pred("no_bypass", 64'h200, 1'b1, 1'b0);
      next_cycle(); fetch(IJXX, 4'h1, 64'h100, 64'h200, 64'h109);
      exec(64'h100, 1'b0, 1'b0);
      exp_pred("after_nt1", 64'h109, 1'b0, 1'b0);
      next_cycle(); fetch(IJXX, 4'h1, 64'h100, 64'h200, 64'h109);
      exp_pred("after_nt2", 64'h109, 1'b0, 1'b0);
      exp_stat("train_stats", 32'd2, 32'd1);

      // RAS overflow with depth 2
      next_cycle(); fetch(ICALL, 4'h0, 64'h500, 64'h1000, 64'h10);
      exp_pred("call1", 64'h1000, 1'b0, 1'b0);
      next_cycle(); fetch(ICALL, 4'h0, 64'h510, 64'h1000, 64'h20);
      next_cycle(); fetch(ICALL, 4'h0, 64'h520, 64'h1000, 64'h30);
      next_cycle(); fetch(IRET, 4'h0, 64'h600, 64'h0, 64'h99);
      exp_pred("ret1", 64'h30, 1'b0, 1'b1);
      next_cycle(); fetch(IRET, 4'h0, 64'h610, 64'h0, 64'h99);
      exp_pred("ret2", 64'h20, 1'b0, 1'b1);
      next_cycle(); fetch(IRET, 4'h0, 64'h620, 64'h0, 64'h99);
      exp_pred("ret3_empty", 64'h99, 1'b0, 1'b0);

      // CALL in the same cycle as a misprediction: clear wins
      next_cycle(); fetch(ICALL, 4'h0, 64'h700, 64'h2000, 64'h50);
      exp_pred("call_a", 64'h2000, 1'b0, 1'b0);
      next_cycle(); fetch(ICALL, 4'h0, 64'h710, 64'h2100, 64'h60);
      exec(64'h100, 1'b1, 1'b0);
      exp_pred("call_mispred", 64'h2100, 1'b0, 1'b0);
      next_cycle(); fetch(IRET, 4'h0, 64'h720, 64'h0, 64'h77);
      exp_pred("ret_after_clear", 64'h77, 1'b0, 1'b0);
      exp_stat("clear_stats", 32'd3, 32'd2);

      // Stall freezes the RAS but not execute-stage training
      next_cycle(); F_stall = 1'b1;
      fetch(ICALL, 4'h0, 64'h800, 64'h3000, 64'h88);
      exec(64'h100, 1'b1, 1'b1);
      exp_pred("stall_call", 64'h3000, 1'b0, 1'b0);
      next_cycle(); fetch(IRET, 4'h0, 64'h810, 64'h0, 64'h44);
      exp_pred("stall_no_push", 64'h44, 1'b0, 1'b0);
      exp_stat("stall_stats", 32'd4, 32'd2);
      next_cycle(); fetch(ICALL, 4'h0, 64'h820, 64'h3100, 64'hAA);
      exp_pred("call_aa", 64'h3100, 1'b0, 1'b0);
      next_cycle(); F_stall = 1'b1; fetch(IRET, 4'h0, 64'h830, 64'h0, 64'h45);
      exp_pred("stall_ret1", 64'hAA, 1'b0, 1'b1);
      next_cycle(); F_stall = 1'b1; fetch(IRET, 4'h0, 64'h830, 64'h0, 64'h45);
      exp_pred("stall_ret2", 64'hAA, 1'b0, 1'b1);
      next_cycle(); fetch(IRET, 4'h0, 64'h830, 64'h0, 64'h45);
      exp_pred("ret_aa", 64'hAA, 1'b0, 1'b1);
      next_cycle(); fetch(IRET, 4'h0, 64'h840, 64'h0, 64'h46);
      exp_pred("ret_aa_gone", 64'h46, 1'b0, 1'b0);

      // Fresh reset, then alternating T/N at PC 0x40 for 32 iterations.
      // Hand trace: mispredicts only on iterations 1 and 3.
      next_cycle(); rst_n = 1'b0;
      next_cycle(); rst_n = 1'b1;
      for (int k = 0; k < 32; k++) begin
         exp_tk = (k < 5) ? 1'b1 : ((k % 2) == 0);
         next_cycle(); fetch(IJXX, 4'h1, 64'h40, 64'h500, 64'h49);
         exp_pred($sformatf("alt%0d", k), exp_tk ? 64'h500 : 64'h49, exp_tk, 1'b0);
         if (k == 16) exp_stat("alt_half_stats", 32'd16, 32'd2);
         next_cycle(); exec(64'h40, exp_tk, ((k % 2) == 0));
      end
      next_cycle();
      exp_stat("alt_final_stats", 32'd32, 32'd2);

      // Mid-stream reset discards training, RAS contents and stats
      next_cycle(); fetch(ICALL, 4'h0, 64'h900, 64'h4000, 64'hBB);
      exp_pred("pre_rst_call", 64'h4000, 1'b0, 1'b0);
      next_cycle(); rst_n = 1'b0;
      exp_stat("mid_rst_stats", 32'd0, 32'd0);
      next_cycle(); rst_n = 1'b1;
      fetch(IJXX, 4'h1, 64'h41, 64'h600, 64'h4A);
      exp_pred("rst_ctr_idx1", 64'h600, 1'b1, 1'b0);
      exp_stat("post_rst_stats", 32'd0, 32'd0);
      next_cycle(); fetch(IJXX, 4'h1, 64'h45, 64'h610, 64'h4E);
      exp_pred("rst_ctr_idx5", 64'h610, 1'b1, 1'b0);
      next_cycle(); fetch(IRET, 4'h0, 64'h950, 64'h0, 64'h12);
      exp_pred("rst_ras_empty", 64'h12, 1'b0, 1'b0);

      next_cycle();
      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL sb_drain left %0d expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bpred_gshare_ras.md
BPRED_GSHARE_RAS -- requirements
Module: bpred_gshare_ras

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 64, number of branch-history-table entries; power of two, 4..1024.
REQ-002 SHALL have parameter CTR_BITS, default 2, saturating-counter width; legal range 1..4.
REQ-003 SHALL have parameter HIST_BITS, default 0, global-history width.
- 0 selects bimodal indexing.
- Values 1..log2(BHT_ENTRIES) select gshare indexing.
REQ-004 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries; power of two, 2..32.
REQ-005 Port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port F_stall_i, input, 1 bit: fetch stage stalled.
REQ-008 Port f_PC_i, input, 64 bits: fetch-stage PC.
REQ-009 Port f_icode_i / f_ifun_i, input, 4 bits each: fetched instruction code and function.
REQ-010 Port f_valC_i / f_valP_i, input, 64 bits each: fetched constant / fall-through PC.
REQ-011 Port E_PC_i, input, 64 bits: execute-stage PC.
REQ-012 Port E_icode_i / E_ifun_i, input, 4 bits each: execute-stage instruction code and function.
REQ-013 Port E_branch_taken_i, input, 1 bit: prediction carried down the pipe with the execute-stage instruction.
REQ-014 Port e_Cnd_i, input, 1 bit: resolved condition.
REQ-015 Port f_predPC_o, output, 64 bits: predicted next PC.
REQ-016 Port f_branch_taken_o, output, 1 bit: conditional-jump prediction.
REQ-017 Port f_ras_hit_o, output, 1 bit: IRET predicted from the RAS.
REQ-018 Port stat_branches_o / stat_mispred_o, output, 32 bits each: resolved conditional jumps / mispredictions.

Function
REQ-019 Prediction SHALL be combinational from f_* inputs and registered state, producing a result in the same cycle as fetch.
REQ-020 f_predPC_o SHALL be selected by f_icode_i as follows:
- IJXX with f_ifun_i==0: f_valC_i, taken=1.
- IJXX with f_ifun_i!=0: f_valC_i if the counter MSB is 1, else f_valP_i; taken = counter MSB.
- ICALL: f_valC_i.
- IRET with RAS non-empty: RAS top, f_ras_hit_o=1.
- IRET with RAS empty: f_valP_i, f_ras_hit_o=0.
- All other icodes: f_valP_i.
REQ-021 f_branch_taken_o SHALL be 0 for every icode other than IJXX; f_ras_hit_o SHALL be 0 for every icode other than IRET.
REQ-022 The BHT index SHALL be computed as follows:
- Bimodal: PC[log2(BHT_ENTRIES)-1:0].
- Gshare: the low HIST_BITS of that index XOR GHR.
- Fetch indexes with f_PC_i; update indexes with E_PC_i.
REQ-023 Update SHALL occur when E_icode_i==IJXX and E_ifun_i!=0.
- Counter increments when e_Cnd_i=1 and decrements when e_Cnd_i=0.
- Counter saturates at 0 and at 2^CTR_BITS-1.
- GHR shifts left with e_Cnd_i inserted at bit 0.
- stat_branches_o increments.
REQ-024 A misprediction is an update cycle with E_branch_taken_i != e_Cnd_i; stat_mispred_o SHALL increment on it; both stat counters wrap modulo 2^32.
REQ-025 A same-cycle fetch read and update write to the same BHT entry SHALL return the pre-update value; there is no bypass, and the update is visible from the next cycle.
REQ-026 RAS push and pop SHALL occur only when F_stall_i=0:
- Push f_valP_i on ICALL.
- Pop on IRET.
REQ-027 RAS overflow behaviour: a push when full SHALL overwrite the oldest entry (circular), with occupancy saturating at RAS_DEPTH.
REQ-028 RAS underflow behaviour: a pop when empty SHALL leave state unchanged.
REQ-029 On a misprediction the RAS SHALL be emptied (occupancy=0); if a push or pop occurs in the same cycle, the clear SHALL win.
REQ-030 With F_stall_i=1, prediction outputs SHALL remain valid while the RAS is unchanged.
- BHT/GHR updates from the execute stage still occur.

Reset
REQ-031 While rst_n_i=0:
- Every BHT counter = 2^(CTR_BITS-1) (weakly taken).
- GHR = 0.
- RAS occupancy = 0.
- Both stat counters = 0.
REQ-032 Immediately after reset, outputs SHALL reflect the reset state: a conditional IJXX predicts taken, and IRET gives f_ras_hit_o=0.
REQ-033 Reset asserted mid-operation SHALL discard all history with no partial update.

Structure
REQ-034 Icode constants (IJXX, ICALL, IRET) SHALL live in shared package y86_pkg; the BHT-index function and counter-saturation constants SHALL also go there.
REQ-035 The RAS SHALL be a sub-module bpred_ras (params RAS_DEPTH; ports push, pop, clear, wdata, top, empty).
- BHT, GHR and stat counters stay in the parent.

Verification
REQ-036 Reset, then fetch IJXX ifun=1 at PC 0x100 with valC=0x200, valP=0x109 -> predPC=0x200, taken=1.
REQ-037 Resolve that PC not-taken twice (CTR_BITS=2) -> the next fetch predicts 0x109 with taken=0; stat_mispred_o=1 and stat_branches_o=2.
REQ-038 With RAS_DEPTH=2, push three CALLs with valP 0x10, 0x20, 0x30; then run IRETs:
- First IRET -> 0x30, ras_hit=1.
- Second IRET -> 0x20, ras_hit=1.
- Third IRET -> ras_hit=0, predPC=valP.
REQ-039 CALL fetched in the same cycle as a misprediction -> RAS is empty afterwards, and the next IRET gives ras_hit=0.
REQ-040 HIST_BITS=4: alternating T/N outcomes at one PC for 32 iterations -> mispredictions in the last 16 iterations = 0.
REQ-041 Assert rst_n_i mid-stream after training -> all counters weakly taken, GHR=0, RAS empty and stats 0 on the next cycle.
